player_motion_ctrl: RTL and testbench

//  Per-player motion controller; successor to the single-jump-plus-one movement FSM.

---
 rtl/movement_pkg.sv | 47 ++++
 rtl/button_edge_tick.sv | 27 ++
 rtl/player_motion_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/movement_pkg.sv
// Shared movement types and tuning defaults for the player motion controller,
// the sprite renderer and the AI driver.
// Contents: movement_state enum, button bundle struct, default motion constants, clamp helper.
package movement_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WALK = 3'd1,
        RUN  = 3'd2,
        RISE = 3'd3,
        FALL = 3'd4
    } movement_state;

    // Controller buttons sampled together on each frame tick.
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } buttons_t;

    // Default tuning, shared so the renderer and AI predict the same trajectories.
    localparam int DEF_MAX_JUMPS   = 2;
    localparam int DEF_JUMP_VEL    = 12;
    localparam int DEF_WALK_VEL    = 3;
    localparam int DEF_RUN_VEL     = 6;
    localparam int DEF_GRAVITY_DIV = 2;
    localparam int DEF_MAX_FALL    = 10;
    localparam int DEF_X_MAX       = 610;
    localparam int DEF_DTAP_WINDOW = 15;
    localparam int DEF_IDLE_HOLD   = 4;

    localparam int POS_W = 10;

    // Clamp a signed intermediate coordinate into [0, hi]; positions saturate, never wrap.
    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [11:0] v,
                                                   input logic [POS_W-1:0]  hi);
        if (v < 12'sd0) begin
            return '0;
        end else if (v > $signed({2'b00, hi})) begin
            return hi;
        end else begin
            return v[POS_W-1:0];
        end
    endfunction

endpackage

// File: rtl/button_edge_tick.sv
// Frame-tick edge detector for the four controller buttons.
// Ports: clk/reset, tick_i (frame enable), btn_i (raw levels), pulse_o (rising edge vs previous tick).
// The previous-level register only advances on ticks, so pulse_o is valid in the tick cycle itself.
module button_edge_tick
    import movement_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     tick_i,
    input  buttons_t btn_i,
    output buttons_t pulse_o
);

    buttons_t prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else if (tick_i) begin
            prev_q <= btn_i;
        end
    end

    // Combinational against the stored level: no extra frame of latency.
    assign pulse_o = btn_i & ~prev_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player motion controller: integrates walk/run/jump/gravity once per frame tick and
// drives sprite position, vertical velocity, facing, jump budget and animation state.
// Ports: clk, reset (async, active-high), frame_rate (tick), button_* inputs, grounded/ground_y
//   from the collision block; x_pos, y_pos, next_y (to collision), y_vel, facing_right,
//   jumps_left, move_state outputs. All state holds between ticks.
// Build option: define FAST_FALL_EN to let button_down slam the fall speed to 2*MAX_FALL;
//   without it button_down is ignored.
module player_motion_ctrl
    import movement_pkg::*;
#(
    parameter int WIDTH       = 0,
    parameter int HEIGHT      = 0,
    parameter int INITIAL_X   = 0,
    parameter int INITIAL_Y   = 0,
    parameter int MAX_JUMPS   = DEF_MAX_JUMPS,
    parameter int JUMP_VEL    = DEF_JUMP_VEL,
    parameter int WALK_VEL    = DEF_WALK_VEL,
    parameter int RUN_VEL     = DEF_RUN_VEL,
    parameter int GRAVITY_DIV = DEF_GRAVITY_DIV,
    parameter int MAX_FALL    = DEF_MAX_FALL,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int DTAP_WINDOW = DEF_DTAP_WINDOW,
    parameter int IDLE_HOLD   = DEF_IDLE_HOLD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_rate,
    input  logic               button_up,
    input  logic               button_down,
    input  logic               button_left,
    input  logic               button_right,
    input  logic               grounded,
    input  logic [9:0]         ground_y,
    output logic [9:0]         x_pos,
    output logic [9:0]         y_pos,
    output logic signed [10:0] next_y,
    output logic signed [7:0]  y_vel,
    output logic               facing_right,
    output logic [2:0]         jumps_left,
    output movement_state      move_state
);

    localparam int DTAP_W = $clog2(DTAP_WINDOW + 2);
    localparam int IDLE_W = $clog2(IDLE_HOLD + 1);
    localparam int GRAV_W = $clog2(GRAVITY_DIV + 1);

    localparam logic [9:0]         X_MAX_L    = 10'(X_MAX);
    localparam logic [9:0]         Y_MAX_L    = 10'd1023;
    localparam logic [9:0]         WALK_V     = 10'(WALK_VEL);
    localparam logic [9:0]         RUN_V      = 10'(RUN_VEL);
    localparam logic signed [7:0]  JUMP_V     = 8'(JUMP_VEL);
    localparam logic signed [7:0]  MAX_FALL_V = 8'(MAX_FALL);
    localparam logic signed [7:0]  FAST_V     = 8'(2 * MAX_FALL);
    localparam logic signed [11:0] GROUND_OFS = 12'(2 * HEIGHT);
    localparam logic [2:0]         MAX_J      = 3'(MAX_JUMPS);
    localparam logic [DTAP_W-1:0]  DTAP_LIM   = DTAP_W'(DTAP_WINDOW);
    localparam logic [IDLE_W-1:0]  IDLE_LIM   = IDLE_W'(IDLE_HOLD);
    localparam logic [GRAV_W-1:0]  GRAV_LAST  = GRAV_W'(GRAVITY_DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic signed [7:0] yv_q, yv_d;
    logic              facing_q, facing_d;
    logic [2:0]        jumps_q, jumps_d;
    movement_state     state_q, state_d;
    logic              running_q, running_d;
    logic [DTAP_W-1:0] dtap_q, dtap_d;   // ticks since last direction pulse; 0 = no prior pulse
    logic [IDLE_W-1:0] idle_q, idle_d;   // consecutive grounded ticks with no direction
    logic [GRAV_W-1:0] grav_q, grav_d;   // airborne ticks toward the next +1 of fall speed

    // ------------------------------------------------------------------
    // Button edges
    // ------------------------------------------------------------------
    buttons_t btn;
    buttons_t pulse;

    assign btn = '{up: button_up, down: button_down, left: button_left, right: button_right};

    button_edge_tick u_edges (
        .clk     (clk),
        .reset   (reset),
        .tick_i  (frame_rate),
        .btn_i   (btn),
        .pulse_o (pulse)
    );

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    logic right_only, left_only, dir_held, dir_pulse, dtap_hit;
    logic jump, airborne;

    assign right_only = button_right & ~button_left;
    assign left_only  = button_left & ~button_right;
    assign dir_held   = button_left | button_right;
    assign dir_pulse  = pulse.left | pulse.right;
    assign dtap_hit   = (dtap_q != '0) && (dtap_q <= DTAP_LIM);

    // A jump takes priority over a landing reported on the same tick.
    assign jump     = pulse.up && (jumps_q != 3'd0);
    assign airborne = jump || !grounded;

    // next_y is computed wide and saturated so a deep fall cannot wrap negative.
    logic signed [11:0] next_y_wide;
    logic signed [10:0] next_y_sat;

    assign next_y_wide = $signed({2'b00, y_q}) + 12'(yv_q);
    assign next_y_sat  = (next_y_wide > 12'sd1023) ? 11'sd1023 : next_y_wide[10:0];

    // ------------------------------------------------------------------
    // Horizontal motion and run detection
    // ------------------------------------------------------------------
    logic [9:0] step;

    always_comb begin
        running_d = running_q;
        if (!dir_held) begin
            running_d = 1'b0;
        end else if (dir_pulse && grounded && dtap_hit) begin
            running_d = 1'b1;
        end

        // Counter saturates one past the window so stale taps never match.
        dtap_d = dtap_q;
        if (dir_pulse) begin
            dtap_d = DTAP_W'(1);
        end else if (dtap_hit) begin
            dtap_d = dtap_q + DTAP_W'(1);
        end

        step     = running_d ? RUN_V : WALK_V;
        x_d      = x_q;
        facing_d = facing_q;
        if (right_only) begin
            x_d      = clamp_pos($signed({2'b00, x_q}) + $signed({2'b00, step}), X_MAX_L);
            facing_d = 1'b1;
        end else if (left_only) begin
            x_d      = clamp_pos($signed({2'b00, x_q}) - $signed({2'b00, step}), X_MAX_L);
            facing_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Vertical motion: jump, landing, gravity
    // ------------------------------------------------------------------
    always_comb begin
        y_d     = y_q;
        yv_d    = yv_q;
        jumps_d = jumps_q;
        grav_d  = grav_q;

        if (jump) begin
            yv_d    = -JUMP_V;
            jumps_d = jumps_q - 3'd1;
            grav_d  = '0;
        end else if (grounded) begin
            y_d     = clamp_pos($signed({2'b00, ground_y}) - GROUND_OFS, Y_MAX_L);
            yv_d    = '0;
            jumps_d = MAX_J;
            grav_d  = '0;
        end else begin
            y_d = next_y_sat[10] ? '0 : next_y_sat[9:0];
            if (grav_q == GRAV_LAST) begin
                grav_d = '0;
                // Only accelerate below terminal speed; a fast-fall speed above it is kept.
                if (yv_q < MAX_FALL_V) begin
                    yv_d = yv_q + 8'sd1;
                end
            end else begin
                grav_d = grav_q + GRAV_W'(1);
            end
`ifdef FAST_FALL_EN
            if (button_down && !yv_q[7]) begin
                yv_d = FAST_V;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Animation state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        if (airborne) begin
            state_d = (yv_d < 8'sd0) ? RISE : FALL;
            idle_d  = '0;
        end else if (dir_held) begin
            state_d = running_d ? RUN : WALK;
            idle_d  = '0;
        end else begin
            if (idle_q != IDLE_LIM) begin
                idle_d = idle_q + IDLE_W'(1);
            end
            // Previous animation lingers until the idle hold has elapsed.
            if (idle_d == IDLE_LIM) begin
                state_d = IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers: one update per frame tick
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q       <= 10'(INITIAL_X);
            y_q       <= 10'(INITIAL_Y);
            yv_q      <= '0;
            facing_q  <= 1'b1;
            jumps_q   <= '0;
            state_q   <= IDLE;
            running_q <= 1'b0;
            dtap_q    <= '0;
            idle_q    <= '0;
            grav_q    <= '0;
        end else if (frame_rate) begin
            x_q       <= x_d;
            y_q       <= y_d;
            yv_q      <= yv_d;
            facing_q  <= facing_d;
            jumps_q   <= jumps_d;
            state_q   <= state_d;
            running_q <= running_d;
            dtap_q    <= dtap_d;
            idle_q    <= idle_d;
            grav_q    <= grav_d;
        end
    end

    assign x_pos        = x_q;
    assign y_pos        = y_q;
    assign next_y       = next_y_sat;
    assign y_vel        = yv_q;
    assign facing_right = facing_q;
    assign jumps_left   = jumps_q;
    assign move_state   = state_q;

    // WIDTH only matters to the collision block; the down edge has no use here.
    logic unused_ok;
    assign unused_ok = &{1'b0, button_down, pulse.down, (WIDTH >= 0)};

endmodule

// File: tb/tb_player_motion_ctrl.sv
`timescale 1ns/1ps
module tb_player_motion_ctrl;
    import movement_pkg::*;

    localparam int HGT = 16, IX = 100, IY = 50;
    localparam int MJ = 2, JV = 12, WV = 3, RV = 6, GD = 2, MF = 10, XM = 610, DW = 15, IH = 4;
`ifdef FAST_FALL_EN
    localparam bit FF_BUILT = 1'b1;
`else
    localparam bit FF_BUILT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, frame_rate, button_up, button_down, button_left, button_right, grounded;
    logic [9:0] ground_y;
    logic [9:0] x_pos, y_pos;
    logic signed [10:0] next_y;
    logic signed [7:0] y_vel;
    logic facing_right;
    logic [2:0] jumps_left;
    movement_state move_state;

    player_motion_ctrl #(.WIDTH(8), .HEIGHT(HGT), .INITIAL_X(IX), .INITIAL_Y(IY)) dut (
        .clk(clk), .reset(reset), .frame_rate(frame_rate),
        .button_up(button_up), .button_down(button_down),
        .button_left(button_left), .button_right(button_right),
        .grounded(grounded), .ground_y(ground_y),
        .x_pos(x_pos), .y_pos(y_pos), .next_y(next_y), .y_vel(y_vel),
        .facing_right(facing_right), .jumps_left(jumps_left), .move_state(move_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain integer bookkeeping from the behavioural rules.
    int m_x, m_y, m_vy, m_face, m_jumps, m_run, m_idle, m_fall, tick_no, last_pulse;
    bit p_up, p_left, p_right;
    movement_state m_st;

    task automatic model_reset();
        m_x = IX; m_y = IY; m_vy = 0; m_face = 1; m_jumps = 0; m_run = 0;
        m_idle = 0; m_fall = 0; tick_no = 0; last_pulse = -1;
        p_up = 0; p_left = 0; p_right = 0; m_st = IDLE;
    endtask

    function automatic int model_ny();
        int s;
        s = m_y + m_vy;
        return (s > 1023) ? 1023 : s;
    endfunction

    task automatic model_tick(input bit u, input bit d, input bit l, input bit r,
                              input bit g, input int gy);
        bit pu, pl, pr, held, jmp;
        int v, ny, old_vy;
        tick_no++;
        pu = u && !p_up; pl = l && !p_left; pr = r && !p_right;
        p_up = u; p_left = l; p_right = r;
        held = l || r;
        if (!held) m_run = 0;
        else if ((pl || pr) && g && last_pulse >= 0 && (tick_no - last_pulse) <= DW) m_run = 1;
        if (pl || pr) last_pulse = tick_no;
        v = m_run ? RV : WV;
        if (r && !l) begin
            m_x = (m_x + v > XM) ? XM : m_x + v; m_face = 1;
        end else if (l && !r) begin
            m_x = (m_x - v < 0) ? 0 : m_x - v; m_face = 0;
        end
        ny = model_ny();
        old_vy = m_vy;
        jmp = pu && (m_jumps > 0);
        if (jmp) begin
            m_vy = -JV; m_jumps--; m_fall = 0;
        end else if (g) begin
            m_y = (gy - 2 * HGT < 0) ? 0 : gy - 2 * HGT;
            m_vy = 0; m_jumps = MJ; m_fall = 0;
        end else begin
            m_y = (ny < 0) ? 0 : ny;
            m_fall++;
            if ((m_fall % GD) == 0 && m_vy < MF) m_vy++;
            if (FF_BUILT && d && old_vy >= 0) m_vy = 2 * MF;
        end
        if (jmp || !g) begin
            m_st = (m_vy < 0) ? RISE : FALL; m_idle = 0;
        end else if (held) begin
            m_st = m_run ? RUN : WALK; m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle >= IH) m_st = IDLE;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_x"}, int'(x_pos), m_x);
        check_val({tag, "_y"}, int'(y_pos), m_y);
        check_val({tag, "_vy"}, int'($signed(y_vel)), m_vy);
        check_val({tag, "_ny"}, int'($signed(next_y)), model_ny());
        check_val({tag, "_face"}, int'(facing_right), m_face);
        check_val({tag, "_jumps"}, int'(jumps_left), m_jumps);
        check_val({tag, "_state"}, int'(move_state), int'(m_st));
    endtask

    // Called at posedge+1; presents inputs, pulses frame_rate for one cycle, then checks.
    task automatic do_tick(input bit u, input bit d, input bit l, input bit r,
                           input bit g, input int gy);
        button_up = u; button_down = d; button_left = l; button_right = r;
        grounded = g; ground_y = 10'(gy);
        frame_rate = 1'b1;
        @(posedge clk); #1;
        frame_rate = 1'b0;
        model_tick(u, d, l, r, g, gy);
        check_outputs("tick");
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, time %0t required below 1ms", $time);
        $fatal(1);
    end

    initial begin
        int gy, nq;
        bit u, d, l, r, g;
        reset = 1'b1; frame_rate = 1'b0;
        button_up = 0; button_down = 0; button_left = 0; button_right = 0;
        grounded = 0; ground_y = '0;
        model_reset();
        #1;
        check_val("rst_x", int'(x_pos), IX);
        check_val("rst_y", int'(y_pos), IY);
        check_val("rst_vy", int'($signed(y_vel)), 0);
        check_val("rst_face", int'(facing_right), 1);
        check_val("rst_jumps", int'(jumps_left), 0);
        check_val("rst_state", int'(move_state), int'(IDLE));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Landing and walking right.
        do_tick(0, 0, 0, 0, 1, 410);
        check_val("t2_land_y", int'(y_pos), 378);
        repeat (3) do_tick(0, 0, 0, 1, 1, 410);
        check_val("t2_x", int'(x_pos), 109);
        check_val("t2_state", int'(move_state), int'(WALK));
        check_val("t2_face", int'(facing_right), 1);

        // Double-tap run, then a too-slow double tap.
        repeat (20) do_tick(0, 0, 0, 0, 1, 410);
        check_val("t3_idle", int'(move_state), int'(IDLE));
        do_tick(0, 0, 0, 1, 1, 410);
        check_val("t3_tap1_x", int'(x_pos), 112);
        repeat (4) do_tick(0, 0, 0, 0, 1, 410);
        do_tick(0, 0, 0, 1, 1, 410);
        check_val("t3_run_x", int'(x_pos), 118);
        check_val("t3_run_state", int'(move_state), int'(RUN));
        do_tick(0, 0, 0, 1, 1, 410);
        check_val("t3_run_x2", int'(x_pos), 124);
        repeat (20) do_tick(0, 0, 0, 0, 1, 410);
        do_tick(0, 0, 0, 1, 1, 410);
        repeat (19) do_tick(0, 0, 0, 0, 1, 410);
        do_tick(0, 0, 0, 1, 1, 410);
        check_val("t3_slow_x", int'(x_pos), 130);
        check_val("t3_slow_state", int'(move_state), int'(WALK));

        // Jump budget: jump off the ground, one air jump, third press ignored.
        do_tick(1, 0, 0, 0, 1, 410);
        check_val("t4_j1_vy", int'($signed(y_vel)), -12);
        check_val("t4_j1_left", int'(jumps_left), 1);
        check_val("t4_j1_state", int'(move_state), int'(RISE));
        repeat (2) do_tick(0, 0, 0, 0, 0, 410);
        check_val("t4_air_vy", int'($signed(y_vel)), -11);
        do_tick(1, 0, 0, 0, 0, 410);
        check_val("t4_j2_vy", int'($signed(y_vel)), -12);
        check_val("t4_j2_left", int'(jumps_left), 0);
        do_tick(0, 0, 0, 0, 0, 410);
        do_tick(1, 0, 0, 0, 0, 410);
        check_val("t4_j3_vy", int'($signed(y_vel)), -11);
        check_val("t4_j3_left", int'(jumps_left), 0);

        // Free fall from rest to terminal speed.
        do_tick(0, 0, 0, 0, 1, 410);
        for (int i = 1; i <= 25; i++) begin
            do_tick(0, 0, 0, 0, 0, 410);
            if (i == 19) check_val("t5_vy19", int'($signed(y_vel)), 9);
            if (i == 20) check_val("t5_vy20", int'($signed(y_vel)), 10);
        end
        check_val("t5_vy_hold", int'($signed(y_vel)), 10);
        check_val("t5_state", int'(move_state), int'(FALL));

        // Fast fall request while falling.
        repeat (3) do_tick(0, 1, 0, 0, 0, 410);
`ifdef FAST_FALL_EN
        check_val("t6_vy", int'($signed(y_vel)), 20);
`else
        check_val("t6_vy", int'($signed(y_vel)), 10);
`endif
        check_val("t6_state", int'(move_state), int'(FALL));

        // Screen bounds: run right into X_MAX, then left into 0.
        do_tick(0, 0, 0, 0, 1, 410);
        do_tick(0, 0, 0, 1, 1, 410);
        do_tick(0, 0, 0, 0, 1, 410);
        repeat (100) do_tick(0, 0, 0, 1, 1, 410);
        check_val("clamp_hi_x", int'(x_pos), XM);
        check_val("clamp_hi_state", int'(move_state), int'(RUN));
        repeat (2) do_tick(0, 0, 0, 0, 1, 410);
        do_tick(0, 0, 1, 0, 1, 410);
        do_tick(0, 0, 0, 0, 1, 410);
        repeat (120) do_tick(0, 0, 1, 0, 1, 410);
        check_val("clamp_lo_x", int'(x_pos), 0);
        check_val("clamp_lo_face", int'(facing_right), 0);

        // Asynchronous reset in mid-air, between clock edges.
        do_tick(0, 0, 0, 0, 1, 410);
        do_tick(1, 0, 0, 1, 1, 410);
        do_tick(0, 0, 0, 1, 0, 410);
        #2 reset = 1'b1;
        #1;
        check_val("t1_x", int'(x_pos), IX);
        check_val("t1_y", int'(y_pos), IY);
        check_val("t1_vy", int'($signed(y_vel)), 0);
        check_val("t1_face", int'(facing_right), 1);
        check_val("t1_jumps", int'(jumps_left), 0);
        check_val("t1_state", int'(move_state), int'(IDLE));
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // Randomized play against the model; collision derived from the model trajectory.
        for (int blk = 0; blk < 4; blk++) begin
            gy = (blk == 0) ? 410 : $urandom_range(150, 460);
            for (int i = 0; i < 120; i++) begin
                u = ($urandom_range(0, 5) == 0);
                d = ($urandom_range(0, 3) == 0);
                l = ($urandom_range(0, 9) < 4);
                r = ($urandom_range(0, 9) < 4);
                g = (model_ny() >= gy - 2 * HGT) || ($urandom_range(0, 24) == 0);
                nq = $urandom_range(0, 2);
                for (int k = 0; k < nq; k++) begin
                    button_up = 1'($urandom); button_down = 1'($urandom);
                    button_left = 1'($urandom); button_right = 1'($urandom);
                    grounded = 1'($urandom);
                    @(posedge clk); #1;
                end
                if (nq > 0) check_outputs("hold");
                do_tick(u, d, l, r, g, gy);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
